// File: rtl/alu_word_sequencer.sv
// Steps a BYTES-wide word operation through an external 8-bit ALU, one byte per cycle,
// LSB first, chaining carry/borrow between slices and returning the word result.
module alu_word_sequencer #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [2:0]           inOp,
  input  logic [8*BYTES-1:0]   inA,
  input  logic [8*BYTES-1:0]   inB,
  input  logic                 inCarry,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [8*BYTES-1:0]   outResult,
  output logic                 outCarry,
  output logic                 outZero,
  output logic                 outError,
  output logic [7:0]           aluA,
  output logic [7:0]           aluB,
  output logic                 aluCarryIn,
  output logic [2:0]           aluOperation,
  input  logic [7:0]           aluResult,
  input  logic                 aluCarryOut
);

  localparam int IDXW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LASTIDX = IDXW'(BYTES - 1);
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  logic [8*BYTES-1:0]   r_a;
  logic [8*BYTES-1:0]   r_b;
  logic [2:0]           r_op;
  logic                 r_carryIn;
  logic                 r_chain;
  logic [IDXW-1:0]      r_byteIdx;
  logic [8*BYTES-1:0]   r_result;
  logic                 r_outCarry;
  logic                 r_outZero;
  logic                 r_outError;
  logic [8*BYTES-1:0]   w_nextResult;
  logic                 w_lastByte;

  assign w_lastByte = (r_byteIdx == LASTIDX);

  // Slices after byte 0 always run the carry-consuming form of the arithmetic op.
  always_comb begin
    aluA         = 8'h00;
    aluB         = 8'h00;
    aluOperation = 3'b000;
    aluCarryIn   = 1'b0;
    if (r_state == RUN) begin
      aluA = r_a[8*r_byteIdx +: 8];
      aluB = r_b[8*r_byteIdx +: 8];
      if (r_op[2]) begin
        aluOperation = r_op;
      end else if (r_byteIdx == '0) begin
        aluOperation = r_op;
        aluCarryIn   = r_op[0] & r_carryIn;
      end else begin
        aluOperation = {1'b0, r_op[1], 1'b1};
        aluCarryIn   = r_chain;
      end
    end
  end

  always_comb begin
    w_nextResult = r_result;
    w_nextResult[8*r_byteIdx +: 8] = aluResult;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'b000;
      r_carryIn  <= 1'b0;
      r_chain    <= 1'b0;
      r_byteIdx  <= '0;
      r_result   <= '0;
      r_outCarry <= 1'b0;
      r_outZero  <= 1'b0;
      r_outError <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inValid) begin
            r_a        <= inA;
            r_b        <= inB;
            r_op       <= inOp;
            r_carryIn  <= inCarry;
            r_chain    <= 1'b0;
            r_byteIdx  <= '0;
            r_result   <= '0;
            r_outCarry <= 1'b0;
            r_outZero  <= (inOp == OP_ILLEGAL);
            r_outError <= (inOp == OP_ILLEGAL);
            r_state    <= (inOp == OP_ILLEGAL) ? DONE : RUN;
          end
        end
        RUN: begin
          r_result <= w_nextResult;
          r_chain  <= aluCarryOut;
          if (w_lastByte) begin
            r_byteIdx  <= '0;
            r_outCarry <= ~r_op[2] & aluCarryOut;
            r_outZero  <= (w_nextResult == '0);
            r_state    <= DONE;
          end else begin
            r_byteIdx <= r_byteIdx + 1'b1;
          end
        end
        DONE: begin
          if (outReady) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ready is gated by rst directly so it drops the moment reset asserts.
  assign inReady   = (r_state == IDLE) && !rst;
  assign outValid  = (r_state == DONE);
  assign outResult = r_result;
  assign outCarry  = r_outCarry;
  assign outZero   = r_outZero;
  assign outError  = r_outError;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_word_sequencer;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inOp;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        inCarry;
  logic        outValid;
  logic        outReady;
  logic [31:0] outResult;
  logic        outCarry;
  logic        outZero;
  logic        outError;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic        aluCarryIn;
  logic [2:0]  aluOperation;
  logic [7:0]  aluResult;
  logic        aluCarryOut;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic [11:0] ops;

  alu_word_sequencer #(.BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .inOp(inOp),
    .inA(inA), .inB(inB), .inCarry(inCarry),
    .outValid(outValid), .outReady(outReady), .outResult(outResult),
    .outCarry(outCarry), .outZero(outZero), .outError(outError),
    .aluA(aluA), .aluB(aluB), .aluCarryIn(aluCarryIn), .aluOperation(aluOperation),
    .aluResult(aluResult), .aluCarryOut(aluCarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 8-bit ALU; for subtraction the carry out is the borrow.
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    case (aluOperation)
      3'b000: t = {1'b0, aluA} + {1'b0, aluB};
      3'b001: t = {1'b0, aluA} + {1'b0, aluB} + {8'd0, aluCarryIn};
      3'b010: t = {1'b0, aluA} - {1'b0, aluB};
      3'b011: t = {1'b0, aluA} - {1'b0, aluB} - {8'd0, aluCarryIn};
      3'b100: t = {1'b0, aluA & aluB};
      3'b101: t = {1'b0, aluA | aluB};
      3'b110: t = {1'b0, aluA ^ aluB};
      default: t = 9'd0;
    endcase
    aluResult   = t[7:0];
    aluCarryOut = t[8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge where outValid is first seen.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, output int nCycles, output logic [11:0] sliceOps);
    inValid = 1'b1;
    inOp    = op;
    inA     = a;
    inB     = b;
    inCarry = cin;
    checkOutput("inReadyAtRequest", 32'(inReady), 32'd1);
    nCycles  = 0;
    sliceOps = 12'd0;
    while (nCycles < 20) begin
      @(negedge clk);
      inValid = 1'b0;
      nCycles++;
      if (outValid) break;
      sliceOps = {sliceOps[8:0], aluOperation};
    end
    if (!outValid) checkOutput("outValidTimeout", 32'(outValid), 32'd1);
  endtask

  task automatic releaseResult();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("inReadyAfterDone", 32'(inReady), 32'd1);
    checkOutput("outValidDropped", 32'(outValid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inOp = 3'b000; inA = '0; inB = '0; inCarry = 1'b0; outReady = 1'b0;
    #3;
    checkOutput("rstInReady", 32'(inReady), 32'd0);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstOutResult", outResult, 32'd0);
    checkOutput("rstFlags", {29'd0, outCarry, outZero, outError}, 32'd0);
    checkOutput("rstAluOut", {13'd0, aluA, aluB, aluOperation}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("inReadyAfterRst", 32'(inReady), 32'd1);
    @(negedge clk);

    applyStimulus(3'b000, 32'h000000FF, 32'h00000001, 1'b0, cycles, ops);
    checkOutput("addLatency", 32'(cycles), 32'd5);
    checkOutput("addSliceOps", 32'(ops), 32'(12'b000_001_001_001));
    checkOutput("addResult", outResult, 32'h00000100);
    checkOutput("addCarry", 32'(outCarry), 32'd0);
    checkOutput("addZero", 32'(outZero), 32'd0);
    releaseResult();

    applyStimulus(3'b000, 32'hFFFFFFFF, 32'h00000001, 1'b0, cycles, ops);
    checkOutput("addWrapResult", outResult, 32'h00000000);
    checkOutput("addWrapCarry", 32'(outCarry), 32'd1);
    checkOutput("addWrapZero", 32'(outZero), 32'd1);
    releaseResult();

    applyStimulus(3'b001, 32'h00000001, 32'h00000001, 1'b1, cycles, ops);
    checkOutput("adcResult", outResult, 32'h00000003);
    checkOutput("adcCarry", 32'(outCarry), 32'd0);
    releaseResult();

    applyStimulus(3'b010, 32'h00000000, 32'h00000001, 1'b0, cycles, ops);
    checkOutput("subResult", outResult, 32'hFFFFFFFF);
    checkOutput("subBorrow", 32'(outCarry), 32'd1);
    checkOutput("subSliceOps", 32'(ops), 32'(12'b010_011_011_011));
    releaseResult();

    applyStimulus(3'b011, 32'd5, 32'd3, 1'b1, cycles, ops);
    checkOutput("sbbResult", outResult, 32'h00000001);
    checkOutput("sbbBorrow", 32'(outCarry), 32'd0);
    releaseResult();

    applyStimulus(3'b110, 32'hA5A5A5A5, 32'hFFFF0000, 1'b1, cycles, ops);
    checkOutput("xorResult", outResult, 32'h5A5AA5A5);
    checkOutput("xorCarry", 32'(outCarry), 32'd0);
    checkOutput("xorSliceOps", 32'(ops), 32'(12'b110_110_110_110));
    releaseResult();

    applyStimulus(3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b1, cycles, ops);
    checkOutput("illLatency", 32'(cycles), 32'd1);
    checkOutput("illError", 32'(outError), 32'd1);
    checkOutput("illResult", outResult, 32'd0);
    checkOutput("illZeroCarry", {30'd0, outZero, outCarry}, 32'd2);
    checkOutput("illAluIdle", {12'd0, aluA, aluB, aluOperation, aluCarryIn}, 32'd0);
    releaseResult();

    // Backpressure: result must hold while outReady stays low and requests are ignored.
    applyStimulus(3'b101, 32'h0F0F0000, 32'h000000F0, 1'b0, cycles, ops);
    checkOutput("orResult", outResult, 32'h0F0F00F0);
    checkOutput("orErrorCleared", 32'(outError), 32'd0);
    inValid = 1'b1; inOp = 3'b000; inA = 32'h1; inB = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bpValid", 32'(outValid), 32'd1);
      checkOutput("bpResult", outResult, 32'h0F0F00F0);
      checkOutput("bpInReady", 32'(inReady), 32'd0);
    end
    inValid = 1'b0;
    releaseResult();
    applyStimulus(3'b100, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b0, cycles, ops);
    checkOutput("b2bLatency", 32'(cycles), 32'd5);
    checkOutput("b2bResult", outResult, 32'h30303030);
    releaseResult();

    // Reset in the middle of RUN aborts the operation.
    inValid = 1'b1; inOp = 3'b000; inA = 32'h12345678; inB = 32'h11111111; inCarry = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("runByte2AluA", 32'(aluA), 32'h34);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortValid", 32'(outValid), 32'd0);
    checkOutput("abortAluOut", {12'd0, aluA, aluB, aluOperation, aluCarryIn}, 32'd0);
    checkOutput("abortInReady", 32'(inReady), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postRstInReady", 32'(inReady), 32'd1);
    checkOutput("postRstValid", 32'(outValid), 32'd0);
    @(negedge clk);
    applyStimulus(3'b000, 32'h12345678, 32'h11111111, 1'b0, cycles, ops);
    checkOutput("postRstLatency", 32'(cycles), 32'd5);
    checkOutput("postRstResult", outResult, 32'h23456789);
    releaseResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
